// File: rtl/instr_encoder_loader_pkg.sv
// Shared types and constants for the instruction encoder/loader.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FMT   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  // Masks select the bits that must all match the sign for the imm to be encodable.
  localparam logic [31:0] MASK_IS = 32'hFFFF_F800;
  localparam logic [31:0] MASK_B  = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J  = 32'hFFF0_0000;

  function automatic logic upper_same(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational RV32I field packer: scatters imm into its format's bit slots and flags errors.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [1:0]  err_code
);

  // Format select; alignment is checked before range so misalignment wins.
  always_comb begin
    word     = 32'h0;
    err_code = ERR_NONE;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!upper_same(imm, MASK_IS)) err_code = ERR_RANGE;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!upper_same(imm, MASK_IS)) err_code = ERR_RANGE;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (imm[0])                        err_code = ERR_ALIGN;
        else if (!upper_same(imm, MASK_B)) err_code = ERR_RANGE;
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'h0) err_code = ERR_RANGE;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])                        err_code = ERR_ALIGN;
        else if (!upper_same(imm, MASK_J)) err_code = ERR_RANGE;
      end
      default: err_code = ERR_FMT;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes field bundles and writes them to imem at auto-incrementing addresses.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [2:0]                   in_fmt,
  input  logic [6:0]                   in_opcode,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [2:0]                   in_funct3,
  input  logic [6:0]                   in_funct7,
  input  logic [31:0]                  in_imm,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         full,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic [$clog2(DEPTH+1)-1:0]   word_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StFull} state_e;

  state_e         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d, done_q, done_d, full_q, full_d, we_q, we_d;
  logic [1:0]     code_q, code_d;
  logic [31:0]    waddr_q, waddr_d, wdata_q, wdata_d;
  logic [31:0]    pack_word;
  logic [1:0]     pack_err;
  logic           full_pending, accept;

  instr_pack u_pack (
    .fmt      (in_fmt),
    .opcode   (in_opcode),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .funct3   (in_funct3),
    .funct7   (in_funct7),
    .imm      (in_imm),
    .word     (pack_word),
    .err_code (pack_err)
  );

  // Next-state: session control, write staging and error/capacity bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    code_d       = code_q;
    done_d       = done_q;
    full_d       = full_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    full_pending = (cnt_q == CW'(DEPTH));
    // start masks ready so a bundle offered in the start cycle is never consumed.
    in_ready     = (state_q == StLoad) && !full_pending && !start;
    accept       = in_valid && in_ready;
    if (start) begin
      state_d = StLoad;
      addr_d  = BASE_ADDR;
      cnt_d   = '0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      done_d  = 1'b0;
      full_d  = 1'b0;
    end else if (accept) begin
      if (pack_err == ERR_NONE) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = pack_word;
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_d == CW'(DEPTH)) begin
          full_d  = 1'b1;
          state_d = StFull;
        end
      end else begin
        err_d = 1'b1;
        if (!err_q) code_d = pack_err;
      end
      if (in_last) begin
        done_d = 1'b1;
        if (state_d != StFull) state_d = StDone;
      end
    end
  end

  // State and output registers; reset drops any staged write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
      done_q  <= done_d;
      full_q  <= full_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = waddr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q == StLoad);
  assign done       = done_q;
  assign full       = full_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed scenarios plus randomized sessions against a behavioural model.
module tb_instr_encoder_loader;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  in_fmt = 3'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_imm = 32'd0;
  logic        in_ready, mem_we, busy, done, full, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  err_code;
  logic [2:0]  word_count;

  instr_encoder_loader #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .err        (err),
    .err_code   (err_code),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  bit          m_active, m_we, m_err, m_done, m_full;
  logic [31:0] m_waddr, m_wdata, m_next;
  int          m_count, m_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word();
    case (in_fmt)
      3'd0: return {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: return {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      3'd2: return {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      3'd3: return {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], in_opcode};
      3'd4: return {in_imm[31:12], in_rd, in_opcode};
      default: return {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
    endcase
  endfunction

  // Error code from signed value ranges: 1 fmt, 3 misaligned, 2 out of range.
  function automatic int ref_code();
    int s;
    s = $signed(in_imm);
    case (in_fmt)
      3'd0: return 0;
      3'd1, 3'd2: return (s >= -2048 && s <= 2047) ? 0 : 2;
      3'd3: begin
        if (s % 2 != 0) return 3;
        return (s >= -4096 && s <= 4095) ? 0 : 2;
      end
      3'd4: return (in_imm % 4096 == 0) ? 0 : 2;
      3'd5: begin
        if (s % 2 != 0) return 3;
        return (s >= -(1 << 20) && s < (1 << 20)) ? 0 : 2;
      end
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_we = 0; m_err = 0; m_done = 0; m_full = 0;
    m_waddr = 0; m_wdata = 0; m_next = BASE; m_count = 0; m_code = 0;
  endtask

  task automatic model_step();
    int c;
    m_we = 0;
    if (start) begin
      m_active = 1; m_next = BASE; m_count = 0;
      m_err = 0; m_code = 0; m_done = 0; m_full = 0;
    end else if (in_valid && m_active) begin
      c = ref_code();
      if (c == 0) begin
        m_we = 1; m_waddr = m_next; m_wdata = ref_word();
        m_next = m_next + 4; m_count++;
        if (m_count == DEPTH) begin m_full = 1; m_active = 0; end
      end else begin
        if (!m_err) m_code = c;
        m_err = 1;
      end
      if (in_last) begin m_done = 1; m_active = 0; end
    end
  endtask

  task automatic compare_all();
    check("we", 32'(mem_we), 32'(m_we));
    if (m_we) begin
      check("addr", mem_addr, m_waddr);
      check("wdata", mem_wdata, m_wdata);
    end
    check("count", 32'(word_count), m_count);
    check("err", 32'(err), 32'(m_err));
    check("err_code", 32'(err_code), m_code);
    check("done", 32'(done), 32'(m_done));
    check("full", 32'(full), 32'(m_full));
    check("busy", 32'(busy), 32'(m_active));
  endtask

  // One clock: check ready against the model, advance model and DUT, compare outputs.
  task automatic tick();
    #1;
    check("in_ready", 32'(in_ready), 32'(m_active && !start));
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm, input bit last);
    in_valid = 1; in_fmt = 3'(fmt); in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = 7'h20; in_imm = imm; in_last = last;
  endtask

  task automatic do_start();
    start = 1; in_valid = 0; in_last = 0;
    tick();
    start = 0;
  endtask

  function automatic logic [31:0] rand_imm();
    int s;
    s = int'($urandom_range(0, 4095)) - 2048;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'(s);
      2: return 32'(s * 2);
      default: return {$urandom_range(0, 1) ? 20'hFFFFF : 20'(s), 12'h0};
    endcase
  endfunction

  int nw;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_flags", {27'h0, busy, done, full, err, in_ready}, 0);
    check("rst_code", 32'(err_code), 0);
    check("rst_count", 32'(word_count), 0);
    rst_n = 1;

    // addi x1, x0, 5
    do_start();
    drive(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 0);
    tick();
    check("t1_we", 32'(mem_we), 1);
    check("t1_addr", mem_addr, 32'h0);
    check("t1_wdata", mem_wdata, 32'h0050_0093);

    // Bundle left valid during start must be ignored.
    start = 1;
    tick();
    start = 0;
    check("start_ignore", 32'(mem_we), 0);
    drive(2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 0);
    tick();
    check("t2_sw", mem_wdata, 32'h0020_A423);
    check("t2_sw_addr", mem_addr, 32'h0);
    drive(3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 0);
    tick();
    check("t2_beq", mem_wdata, 32'hFE00_0EE3);
    check("t2_beq_addr", mem_addr, 32'h4);
    check("t2_count", 32'(word_count), 2);

    do_start();
    drive(4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 0);
    tick();
    check("t3_lui", mem_wdata, 32'h1234_52B7);
    drive(5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8, 1);
    tick();
    check("t3_jal", mem_wdata, 32'h0080_00EF);
    check("t3_jal_addr", mem_addr, 32'h4);
    check("t3_done", 32'(done), 1);
    check("t3_ready", 32'(in_ready), 0);
    in_valid = 0; in_last = 0;
    tick();

    do_start();
    drive(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 0);
    tick();
    check("t4_range_we", 32'(mem_we), 0);
    check("t4_range_code", 32'(err_code), 2);
    drive(3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd7, 0);
    tick();
    check("t4_keep_code", 32'(err_code), 2);
    check("t4_err", 32'(err), 1);
    drive(1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1, 0);
    tick();
    check("t4_addr_kept", mem_addr, 32'h0);

    // Hold valid for six bundles; only DEPTH may be written.
    do_start();
    nw = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 32'(i), 0);
      tick();
      if (mem_we) begin
        check("t5_addr", mem_addr, 32'(nw * 4));
        nw++;
      end
    end
    check("t5_writes", nw, DEPTH);
    check("t5_full", 32'(full), 1);
    check("t5_ready", 32'(in_ready), 0);

    // Reset while a write is about to be registered.
    do_start();
    drive(1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd9, 0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("t6_we", 32'(mem_we), 0);
    check("t6_flags", {27'h0, busy, done, full, err, in_ready}, 0);
    check("t6_count", 32'(word_count), 0);
    @(posedge clk);
    #1;
    check("t6_hold_we", 32'(mem_we), 0);
    rst_n = 1;
    do_start();
    drive(1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 32'd9, 0);
    tick();
    check("t6_addr", mem_addr, BASE);
    check("t6_count1", 32'(word_count), 1);

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      do_start();
      for (int c = 0; c < 10; c++) begin
        drive(int'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 3'($urandom), rand_imm(), $urandom_range(0, 7) == 0);
        in_valid = $urandom_range(0, 3) != 0;
        start = $urandom_range(0, 15) == 0;
        tick();
        start = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
